// File: rtl/ext_mem_wait_if.sv
// rtl/ext_mem_wait_if.sv - LSU data-port bundle between a requester and ext_mem_wait
//
// Purpose: groups the request/response signals of the wait-state data memory.
// Ports (signals):
//   mem_req_i       requester -> memory  request, held until ready_o
//   write_enable_i  requester -> memory  1 = write, 0 = read
//   addr_i          requester -> memory  byte address (32 bits)
//   write_data_i    requester -> memory  write data
//   byte_enable_i   requester -> memory  per-byte write strobe
//   read_data_o     memory -> requester  registered read data
//   ready_o         memory -> requester  one-cycle completion strobe
//   err_o           memory -> requester  out-of-range strobe, coincident with ready_o
interface ext_mem_wait_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      mem_req_i;
  logic                      write_enable_i;
  logic [31:0]               addr_i;
  logic [DATA_WIDTH-1:0]     write_data_i;
  logic [DATA_WIDTH/8-1:0]   byte_enable_i;
  logic [DATA_WIDTH-1:0]     read_data_o;
  logic                      ready_o;
  logic                      err_o;

  modport master (
    output mem_req_i, write_enable_i, addr_i, write_data_i, byte_enable_i,
    input  read_data_o, ready_o, err_o
  );

  modport slave (
    input  mem_req_i, write_enable_i, addr_i, write_data_i, byte_enable_i,
    output read_data_o, ready_o, err_o
  );
endinterface

// File: rtl/ext_mem_wait.sv
// rtl/ext_mem_wait.sv - word-addressed byte-enable RAM with configurable wait states
//
// Purpose: data memory for the LSU port that completes each access LATENCY
// cycles after acceptance, flags out-of-range addresses, and accepts at most
// one transaction every LATENCY+1 cycles.
// Ports:
//   clk_i  clock, all logic on the rising edge
//   rst_i  synchronous active-high reset of the interface state (not the array)
//   bus    ext_mem_wait_if.slave: request, write data/strobes, read data,
//          ready_o completion strobe and err_o out-of-range strobe
module ext_mem_wait #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LATENCY     = 3,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ext_mem_wait_if.slave bus
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BE_W);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int CNT_W    = 4;
  // Remaining WAIT cycles after acceptance; the completing edge is the one
  // ending cycle N+LATENCY-1 so that ready_o is high in cycle N+LATENCY.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_we;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]       lat_be;
  logic                  lat_oor;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;

  logic [IDX_W-1:0] req_idx;
  logic             req_oor;

  assign req_idx = IDX_W'(bus.addr_i >> ADDR_LSB);
  assign req_oor = (bus.addr_i >> (ADDR_LSB + IDX_W)) != 32'd0;

  // Operation performed at this edge. With LATENCY=1 the completing edge is
  // the accepting edge, so the live inputs stand in for the latched copies.
  logic                  op_fire;
  logic                  op_we;
  logic [IDX_W-1:0]      op_idx;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [BE_W-1:0]       op_be;
  logic                  op_oor;

  always_comb begin
    op_fire  = 1'b0;
    op_we    = lat_we;
    op_idx   = lat_idx;
    op_wdata = lat_wdata;
    op_be    = lat_be;
    op_oor   = lat_oor;
    if (state == S_IDLE && bus.mem_req_i && LATENCY == 1) begin
      op_fire  = 1'b1;
      op_we    = bus.write_enable_i;
      op_idx   = req_idx;
      op_wdata = bus.write_data_i;
      op_be    = bus.byte_enable_i;
      op_oor   = req_oor;
    end else if (state == S_WAIT && cnt == '0) begin
      op_fire  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mem_req_i) begin
            lat_we    <= bus.write_enable_i;
            lat_idx   <= req_idx;
            lat_wdata <= bus.write_data_i;
            lat_be    <= bus.byte_enable_i;
            lat_oor   <= req_oor;
            if (LATENCY == 1) begin
              state <= S_DONE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= S_DONE;
        end
        // The request is still high here but belongs to the finished access.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (op_fire) begin
        ready <= 1'b1;
        err   <= op_oor;
        if (!op_we) rdata <= op_oor ? '0 : mem[op_idx];
      end
    end
  end

  // Array has no reset; a write pending at reset is dropped by the rst_i gate.
  always_ff @(posedge clk_i) begin
    if (!rst_i && op_fire && op_we && !op_oor) begin
      for (int k = 0; k < BE_W; k++) begin
        if (op_be[k]) mem[op_idx][8*k +: 8] <= op_wdata[8*k +: 8];
      end
    end
  end

  assign bus.read_data_o = rdata;
  assign bus.ready_o     = ready;
  assign bus.err_o       = err;

endmodule
